pix_filter_pipe: RTL

Pipelined, parametrised successor to the combinational RGB colour-filter stage in the camera path (sensor capture → filter → frame buffer/VGA).
- Applies one of several per-pixel filters selected by the 8-bit ASCII command code.
- Adds valid/ready flow control, frame-synchronous mode switching, a programmable binary threshold, saturating arithmetic and a fixed 3-stage pipeline.
- Sits between the capture/pixel-packing logic and the frame-buffer write port.

---
 rtl/pix_filter_pipe.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pix_filter_pipe.sv
// pix_filter_pipe: 3-stage valid/ready per-pixel colour filter (gray, binary,
// invert, desaturate, sepia, passthrough) with a filter mode latched per frame.
module pix_filter_pipe #(
    parameter int unsigned CW     = 4,
    parameter int unsigned THRESH = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        oper,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic [3*CW-1:0]   in_rgb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic [3*CW-1:0]   out_rgb,
    output logic [7:0]        active_mode
);

    localparam int unsigned PW = 3 * CW;
    localparam int unsigned SH = 8 - CW;

    localparam logic [7:0] MODE_PASS  = 8'h30;
    localparam logic [7:0] MODE_GRAY  = 8'h31;
    localparam logic [7:0] MODE_BIN   = 8'h32;
    localparam logic [7:0] MODE_INV   = 8'h33;
    localparam logic [7:0] MODE_DESAT = 8'h34;
    localparam logic [7:0] MODE_SEPIA = 8'h38;

    // Saturate a 10-bit intermediate result to the 8-bit channel range.
    function automatic logic [7:0] sat8(input logic [9:0] x);
        return (x > 10'd255) ? 8'hFF : x[7:0];
    endfunction

    logic       adv;
    logic       accept;
    logic [7:0] mode_q;
    logic [7:0] mode_in;
    logic [7:0] in_r8, in_g8, in_b8;

    logic       s1_valid, s1_sof, s1_eol;
    logic [7:0] s1_mode, s1_r, s1_g, s1_b;

    logic       s2_valid, s2_sof, s2_eol;
    logic [9:0] s2_r, s2_g, s2_b;

    logic [9:0]  sum10;
    logic [7:0]  mean8;
    logic [7:0]  mx, mn;
    logic [8:0]  mid9;
    logic [7:0]  desat8;
    logic [19:0] sep_r, sep_g, sep_b;
    logic [9:0]  res_r, res_g, res_b;
    logic [7:0]  sat_r, sat_g, sat_b;

    // Whole pipeline moves together; it only stalls when a held output is not taken.
    assign adv         = ~out_valid | out_ready;
    assign in_ready    = adv;
    assign accept      = in_valid & adv;
    assign active_mode = mode_q;

    // A start-of-frame pixel uses the command presented with it.
    assign mode_in = in_sof ? oper : mode_q;

    // Left-align each channel into 8 bits, zero-filling the low bits.
    assign in_r8 = 8'(in_rgb[PW-1 -: CW]) << SH;
    assign in_g8 = 8'(in_rgb[2*CW-1 -: CW]) << SH;
    assign in_b8 = 8'(in_rgb[CW-1 -: CW]) << SH;

    // Frame-level mode register, updated only by an accepted sof beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_PASS;
        end else if (accept && in_sof) begin
            mode_q <= oper;
        end
    end

    // S1: expanded pixel, sideband and the mode this pixel carries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_mode  <= MODE_PASS;
            s1_r     <= 8'd0;
            s1_g     <= 8'd0;
            s1_b     <= 8'd0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sof   <= in_sof;
            s1_eol   <= in_eol;
            s1_mode  <= mode_in;
            s1_r     <= in_r8;
            s1_g     <= in_g8;
            s1_b     <= in_b8;
        end
    end

    // Shared intermediates: mean, max/min midpoint, full-width sepia sums.
    always_comb begin
        sum10  = 10'(s1_r) + 10'(s1_g) + 10'(s1_b);
        mean8  = 8'(sum10 / 10'd3);
        mx     = s1_r;
        mn     = s1_r;
        if (s1_g > mx) mx = s1_g;
        if (s1_b > mx) mx = s1_b;
        if (s1_g < mn) mn = s1_g;
        if (s1_b < mn) mn = s1_b;
        mid9   = 9'(mx) + 9'(mn);
        desat8 = 8'(mid9 >> 1);
        sep_r  = 20'(s1_r) * 20'd403 + 20'(s1_g) * 20'd788 + 20'(s1_b) * 20'd194;
        sep_g  = 20'(s1_r) * 20'd357 + 20'(s1_g) * 20'd702 + 20'(s1_b) * 20'd172;
        sep_b  = 20'(s1_r) * 20'd279 + 20'(s1_g) * 20'd547 + 20'(s1_b) * 20'd134;
    end

    // Per-mode channel result, before saturation.
    always_comb begin
        res_r = 10'(s1_r);
        res_g = 10'(s1_g);
        res_b = 10'(s1_b);
        case (s1_mode)
            MODE_GRAY: begin
                res_r = 10'(mean8);
                res_g = 10'(mean8);
                res_b = 10'(mean8);
            end
            MODE_BIN: begin
                res_r = (mean8 >= 8'(THRESH)) ? 10'd255 : 10'd0;
                res_g = res_r;
                res_b = res_r;
            end
            MODE_INV: begin
                res_r = 10'(8'hFF - s1_r);
                res_g = 10'(8'hFF - s1_g);
                res_b = 10'(8'hFF - s1_b);
            end
            MODE_DESAT: begin
                res_r = 10'(desat8);
                res_g = 10'(desat8);
                res_b = 10'(desat8);
            end
            MODE_SEPIA: begin
                res_r = 10'(sep_r >> 10);
                res_g = 10'(sep_g >> 10);
                res_b = 10'(sep_b >> 10);
            end
            default: begin
                res_r = 10'(s1_r);
                res_g = 10'(s1_g);
                res_b = 10'(s1_b);
            end
        endcase
    end

    // S2: unsaturated results with sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            s2_r     <= 10'd0;
            s2_g     <= 10'd0;
            s2_b     <= 10'd0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;
            s2_r     <= res_r;
            s2_g     <= res_g;
            s2_b     <= res_b;
        end
    end

    assign sat_r = sat8(s2_r);
    assign sat_g = sat8(s2_g);
    assign sat_b = sat8(s2_b);

    // S3: clamped, truncated output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_rgb   <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_sof   <= s2_sof;
            out_eol   <= s2_eol;
            out_rgb   <= {CW'(sat_r >> SH), CW'(sat_g >> SH), CW'(sat_b >> SH)};
        end
    end

endmodule
